// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the two-port memory arbiter.
// Exports arb_state_t, port_vec_t, NUM_PORTS, ADDR_W and the port_id helper.
package mem_arb_pkg;

   localparam int NUM_PORTS = 2;
   localparam int ADDR_W    = 8;

   typedef enum logic {
      IDLE   = 1'b0,
      ACCESS = 1'b1
   } arb_state_t;

   typedef logic [NUM_PORTS-1:0] port_vec_t;

   // Port number of a one-hot two-way grant (0 when port 0 or nobody).
   function automatic logic port_id(input port_vec_t g);
      return g[1];
   endfunction

endpackage

// File: rtl/mem_arbiter_rr.sv
// rr_arbiter2: two-way arbiter with a registered last_grant.
// Ports: clk, rst_n, req[1:0] (qualified requests), grant[1:0] (one-hot, comb).
// Build option: MEM_ARB_FIXED_PRIO_EN selects fixed priority (port 0 wins ties).
module rr_arbiter2
   import mem_arb_pkg::*;
(
   input  logic      clk,
   input  logic      rst_n,
   input  port_vec_t req,
   output port_vec_t grant
);

   logic last_grant;

   // Reset value 1 makes port 0 the winner of the first tie.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_grant <= 1'b1;
      end else if (|grant) begin
         last_grant <= port_id(grant);
      end
   end

   always_comb begin
      grant = '0;
      unique case (req)
         2'b01: grant = 2'b01;
         2'b10: grant = 2'b10;
`ifdef MEM_ARB_FIXED_PRIO_EN
         2'b11: grant = 2'b01;
`else
         2'b11: grant = last_grant ? 2'b01 : 2'b10;
`endif
         default: grant = '0;
      endcase
   end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates two requesters onto a 256 x 2*WIDTH memory.
// Ports: pN_valid/ready/write/addr/wdata request side, pN_resp_valid and
// resp_rdata response side, memory* strobes/address/data to the memory.
// Build option: MEM_ARB_FIXED_PRIO_EN (fixed priority instead of round robin).
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                p0_valid,
   output logic                p0_ready,
   input  logic                p0_write,
   input  logic [ADDR_W-1:0]   p0_addr,
   input  logic [2*WIDTH-1:0]  p0_wdata,
   output logic                p0_resp_valid,
   input  logic                p1_valid,
   output logic                p1_ready,
   input  logic                p1_write,
   input  logic [ADDR_W-1:0]   p1_addr,
   input  logic [2*WIDTH-1:0]  p1_wdata,
   output logic                p1_resp_valid,
   output logic [2*WIDTH-1:0]  resp_rdata,
   output logic                memoryWrite,
   output logic                memoryRead,
   output logic [ADDR_W-1:0]   memoryAddress,
   output logic [2*WIDTH-1:0]  memoryWriteData,
   input  logic [2*WIDTH-1:0]  memoryOutData
);

   localparam int DW = 2 * WIDTH;

   typedef struct packed {
      logic              write;
      logic [ADDR_W-1:0] addr;
      logic [DW-1:0]     wdata;
   } mem_req_t;

   arb_state_t state;
   arb_state_t state_nxt;
   mem_req_t   req_q;
   mem_req_t   req_sel;
   logic       port_q;
   port_vec_t  req_vec;
   port_vec_t  grant;
   logic       handshake;

   // Requests are only arbitrated while idle, so ready is low in ACCESS.
   assign req_vec = (state == IDLE) ? {p1_valid, p0_valid} : '0;

   rr_arbiter2 u_arb (
      .clk   (clk),
      .rst_n (rst_n),
      .req   (req_vec),
      .grant (grant)
   );

   assign p0_ready  = grant[0];
   assign p1_ready  = grant[1];
   assign handshake = |grant;

   always_comb begin
      req_sel.write = p0_write;
      req_sel.addr  = p0_addr;
      req_sel.wdata = p0_wdata;
      if (grant[1]) begin
         req_sel.write = p1_write;
         req_sel.addr  = p1_addr;
         req_sel.wdata = p1_wdata;
      end
   end

   // Strobes decode straight from state, so an async reset in ACCESS
   // kills memoryWrite before the closing edge.
   always_comb begin
      state_nxt   = state;
      memoryWrite = 1'b0;
      memoryRead  = 1'b0;
      unique case (state)
         IDLE: begin
            if (handshake) state_nxt = ACCESS;
         end
         ACCESS: begin
            memoryWrite = req_q.write;
            memoryRead  = !req_q.write;
            state_nxt   = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         req_q         <= '0;
         port_q        <= 1'b0;
         p0_resp_valid <= 1'b0;
         p1_resp_valid <= 1'b0;
         resp_rdata    <= '0;
      end else begin
         state         <= state_nxt;
         p0_resp_valid <= (state == ACCESS) && !port_q;
         p1_resp_valid <= (state == ACCESS) && port_q;
         if (handshake) begin
            req_q  <= req_sel;
            port_q <= port_id(grant);
         end
         if ((state == ACCESS) && !req_q.write) begin
            resp_rdata <= memoryOutData;
         end
      end
   end

   assign memoryAddress   = req_q.addr;
   assign memoryWriteData = req_q.wdata;

   a_strobe_excl: assert property (
      @(posedge clk) disable iff (!rst_n) !(memoryRead && memoryWrite));

   a_ready_excl: assert property (
      @(posedge clk) disable iff (!rst_n) !(p0_ready && p1_ready));

   a_resp_excl: assert property (
      @(posedge clk) disable iff (!rst_n) !(p0_resp_valid && p1_resp_valid));

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-requester controller for the shared 256 x 2*WIDTH memory.
- Arbitrates between requesters p0 and p1, which are typically instruction fetch and data load/store.
- Sequences each accepted request into a single-cycle memory access, with exactly one of memoryRead or memoryWrite asserted.
- Returns read data, or a write acknowledgement, to the granted requester.
- Sits between the CPU control unit and the memory block; the memory block is the arbiter's only client-side target.

Parameters:
- WIDTH, 8: datapath half-width. Memory word and requester data are 2*WIDTH bits. The address is fixed at 8 bits (256 words).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- p0_valid  in  1  port 0 request valid.
- p0_ready  out  1  port 0 request accepted this cycle.
- p0_write  in  1  port 0: 1=write, 0=read.
- p0_addr  in  8  port 0 word address.
- p0_wdata  in  2*WIDTH  port 0 write data.
- p0_resp_valid  out  1  port 0 response pulse.
- p1_valid, p1_ready, p1_write, p1_addr, p1_wdata, p1_resp_valid: as port 0, for port 1.
- resp_rdata  out  2*WIDTH  read data for the port whose resp_valid is high.
- memoryWrite  out  1  memory write strobe.
- memoryRead  out  1  memory read enable.
- memoryAddress  out  8  memory address.
- memoryWriteData  out  2*WIDTH  memory write data.
- memoryOutData  in  2*WIDTH  memory read data (combinational from the memory).

Behaviour:
- Reset: all outputs are 0 and the FSM is IDLE. last_grant = 1, so port 0 wins the first tie.
- FSM state IDLE:
  - Arbitration is combinational from p0_valid and p1_valid.
  - Only one port is valid: that port is selected.
  - Both ports are valid: the port != last_grant is selected (round robin).
  - The selected port's pN_ready = 1, combinationally, in the same cycle.
  - A handshake (valid & ready) registers write, addr, wdata and port id, updates last_grant, and moves the FSM to ACCESS.
  - No port is valid: the FSM stays in IDLE.
- FSM state ACCESS (exactly 1 cycle):
  - Both ready signals are 0.
  - memoryAddress and memoryWriteData are driven from the registered request.
  - memoryWrite = req_write and memoryRead = !req_write; the two are never high together.
  - On the closing edge, a read captures memoryOutData into resp_rdata. A write lands in the memory on the same edge.
  - The FSM then returns to IDLE.
- Response:
  - pN_resp_valid pulses for exactly one cycle in the cycle after ACCESS, for both reads and writes.
  - resp_rdata holds its value until the next read completes. It is not updated on writes.
- Timing:
  - Handshake in cycle N, ACCESS in N+1, resp_valid in N+2.
  - A new handshake may occur in N+2, in parallel with the response.
  - Peak throughput is one access per 2 cycles.
- memoryRead and memoryWrite are both 0 outside ACCESS. memoryAddress holds its last value.
- A requester must hold valid and its payload stable until ready. Dropping valid before ready is legal; that request is simply not served.
- Read-after-write to the same address from either port returns the new data, because the write completes in ACCESS before the next ACCESS.
- Reset asserted mid-ACCESS:
  - memoryWrite drops immediately (asynchronous reset), so no partial write is committed.
  - The pending response is discarded.
  - last_grant returns to 1.
- Address width is fixed at 8 bits with no wrap logic; all 256 addresses are valid.

Optional Feature:
- Macro: MEM_ARB_FIXED_PRIO_EN.
- Defined: fixed priority. Port 0 always wins when both ports are valid, and last_grant is not used for arbitration. Port 1 can starve.
- Undefined: round-robin arbitration as described above.

Decomposition:
- Package mem_arb_pkg:
  - typedef enum logic {IDLE, ACCESS} arb_state_t.
  - localparam NUM_PORTS = 2.
  - localparam ADDR_W = 8.
  - struct mem_req_t {write, addr, wdata}, parameterised via WIDTH in the module.
- One natural sub-module, rr_arbiter2: a 2-way round-robin grant with a registered last_grant.
- The FSM, request register and response logic stay in mem_arbiter.

Test Plan:
- Single write, then read: p0 writes addr 0x10, data 0xBEEF (p0_resp_valid 2 cycles after the handshake). p0 then reads 0x10 -> resp_rdata = 0xBEEF and p0_resp_valid at N+2.
- Simultaneous requests: p0 and p1 both valid and reading from reset.
  - Grant order is p0, p1, p0, p1.
  - Handshakes occur 2 cycles apart.
  - The ready signals are never both high.
  - With MEM_ARB_FIXED_PRIO_EN defined, p0 is granted every time while held valid.
- Cross-port coherence: p1 writes 0xFF = 0x1234, and p0 reads 0xFF in the next IDLE -> 0x1234.
- Strobe exclusivity: a random mix of 1000 requests. Check that:
  - memoryRead & memoryWrite is never 1;
  - strobes appear only in ACCESS;
  - each handshake yields exactly one resp_valid pulse on the correct port.
- Reset mid-op: p0 write of 0xAAAA to 0x20 is accepted, and rst_n is pulled low during ACCESS. Then:
  - memoryWrite falls immediately;
  - no resp_valid appears;
  - after release, a p0 read of 0x20 returns the pre-reset contents;
  - p0 wins the first tie.
- Boundary addresses: write/read 0x00 and 0xFF with 0x0000 and 0xFFFF -> exact readback. resp_rdata is unchanged across an intervening write response.
